// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32 multiplier controller driving a shared 16x16 unsigned cell.
// Four partial products are accumulated, then a signed fix-up is applied to the upper word.
module mul_seq_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        op_signed,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] res_data,
   output logic [15:0] mul_a,
   output logic [15:0] mul_b,
   output logic        mul_en,
   input  logic [31:0] mul_result,
   output logic        busy,
   output logic [15:0] op_count
);

   typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FIX, DONE} state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] a_r;
   logic [31:0] b_r;
   logic        signed_r;
   logic [63:0] acc;
   logic [1:0]  issue_idx;
   logic [1:0]  prod_idx;
   logic        prod_vld;
   logic [63:0] prod_shifted;
   logic [31:0] corr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      op_ready  = 1'b0;
      mul_en    = 1'b0;
      mul_a     = '0;
      mul_b     = '0;
      res_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            op_ready = 1'b1;
            if (op_valid) state_nx = ISSUE;
         end
         ISSUE: begin
            mul_en = 1'b1;
            // idx bit1 selects the A half, bit0 the B half: lo*lo, lo*hi, hi*lo, hi*hi
            mul_a  = issue_idx[1] ? a_r[31:16] : a_r[15:0];
            mul_b  = issue_idx[0] ? b_r[31:16] : b_r[15:0];
            if (issue_idx == 2'd3) state_nx = DRAIN;
         end
         DRAIN: state_nx = FIX;
         FIX:   state_nx = DONE;
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      prod_shifted = '0;
      case (prod_idx)
         2'd0:    prod_shifted = {32'd0, mul_result};
         2'd3:    prod_shifted = {mul_result, 32'd0};
         default: prod_shifted = {16'd0, mul_result, 16'd0};
      endcase
      corr = (a_r[31] ? b_r : 32'd0) + (b_r[31] ? a_r : 32'd0);
   end

   // prod_vld tracks the cell's one-cycle latency; clearing it on reset drops stale products
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_r       <= '0;
         b_r       <= '0;
         signed_r  <= 1'b0;
         acc       <= '0;
         issue_idx <= '0;
         prod_idx  <= '0;
         prod_vld  <= 1'b0;
         op_count  <= '0;
      end else begin
         prod_vld <= mul_en;
         prod_idx <= issue_idx;
         if (state == IDLE && op_valid) begin
            a_r       <= op_a;
            b_r       <= op_b;
            signed_r  <= op_signed;
            acc       <= '0;
            issue_idx <= '0;
         end
         if (state == ISSUE) issue_idx <= issue_idx + 2'd1;
         if (prod_vld) acc <= acc + prod_shifted;
         if (state == FIX && signed_r) acc[63:32] <= acc[63:32] - corr;
         if (state == DONE && res_ready) op_count <= op_count + 16'd1;
      end
   end

   assign res_data = acc;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: stimulus queues expected results and issue pairs,
// a negedge monitor compares whenever the DUT issues to the cell or presents a result.
module tb_mul_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        op_signed;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_data;
   logic [15:0] mul_a;
   logic [15:0] mul_b;
   logic        mul_en;
   logic [31:0] mul_result = '0;
   logic        busy;
   logic [15:0] op_count;

   mul_seq_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .op_signed  (op_signed),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_en     (mul_en),
      .mul_result (mul_result),
      .busy       (busy),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Shared 16x16 cell: registers the product at the edge ending an enabled cycle
   always @(posedge clk) if (mul_en) mul_result <= 32'(mul_a) * 32'(mul_b);

   typedef struct {
      logic [63:0] data;
      int unsigned t_acc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] iss_q[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   logic [15:0] exp_count = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   // Monitor
   initial begin
      logic        rv_prev = 1'b0;
      logic        hs_prev = 1'b0;
      logic [63:0] held    = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            rv_prev = 1'b0;
            hs_prev = 1'b0;
         end else begin
            if (hs_prev) begin
               check("idle_after_handshake", {62'd0, op_ready, res_valid}, 64'd2);
               hs_prev = 1'b0;
            end
            if (mul_en) begin
               if (iss_q.size() == 0) check("spurious_mul_en", 64'(mul_en), 64'd0);
               else check("issue_order", {32'd0, mul_a, mul_b}, 64'(iss_q.pop_front()));
            end else begin
               check("mul_operands_idle", {32'd0, mul_a, mul_b}, 64'd0);
            end
            if (res_valid) begin
               check("op_ready_while_result", 64'(op_ready), 64'd0);
               if (!rv_prev) begin
                  if (exp_q.size() == 0) check("spurious_res_valid", 64'(res_valid), 64'd0);
                  else begin
                     check("latency", 64'(cyc - exp_q[0].t_acc), 64'd7);
                     check("res_data", res_data, exp_q[0].data);
                  end
                  held = res_data;
               end else begin
                  check("res_data_stable", res_data, held);
               end
               if (res_ready && exp_q.size() != 0) begin
                  exp_q.delete(0);
                  hs_prev = 1'b1;
               end
            end
            rv_prev = res_valid;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [63:0] exp_data);
      exp_t e;
      int unsigned w = 0;
      @(posedge clk); #1;
      while (!op_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      check("op_ready_before_accept", 64'(op_ready), 64'd1);
      op_valid  = 1'b1;
      op_a      = a;
      op_b      = b;
      op_signed = s;
      e.data    = exp_data;
      e.t_acc   = cyc;
      exp_q.push_back(e);
      iss_q.push_back({a[15:0],  b[15:0]});
      iss_q.push_back({a[15:0],  b[31:16]});
      iss_q.push_back({a[31:16], b[15:0]});
      iss_q.push_back({a[31:16], b[31:16]});
      @(posedge clk); #1;
      // Operand changes after acceptance must not disturb the operation
      op_valid  = 1'b0;
      op_a      = ~a;
      op_b      = b ^ 32'h5A5A_A5A5;
      op_signed = ~s;
   endtask

   task automatic wait_done();
      int unsigned w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (busy && w < 60);
      check("done_timeout_busy", 64'(busy), 64'd0);
      exp_count = exp_count + 16'd1;
      check("op_count", 64'(op_count), 64'(exp_count));
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [63:0] p;
   } vec_t;

   vec_t vecs[10] = '{
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001},
      '{32'h8000_0000, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_0000_0000},
      '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA},
      '{32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 64'h0000_0002_FFFF_FFFA},
      '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000},
      '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000},
      '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF},
      '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001},
      '{32'h0000_0000, 32'h1234_5678, 1'b1, 64'h0000_0000_0000_0000}
   };

   initial begin
      int unsigned w;
      reset     = 1'b1;
      op_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      op_signed = 1'b0;
      res_ready = 1'b1;

      #2;
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_data",  res_data,        64'd0);
      check("rst_mul_en",    64'(mul_en),    64'd0);
      check("rst_mul_ab",    {32'd0, mul_a, mul_b}, 64'd0);
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_op_count",  64'(op_count),  64'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1 check("rst_op_ready", 64'(op_ready), 64'd1);

      foreach (vecs[i]) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p);
         wait_done();
      end

      // Result held for 5 cycles under back-pressure
      res_ready = 1'b0;
      start_op(32'h0001_2345, 32'h0001_0000, 1'b0, 64'h0000_0001_2345_0000);
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!res_valid && w < 20);
      repeat (5) @(negedge clk);
      check("hold_res_valid", 64'(res_valid), 64'd1);
      check("hold_res_data",  res_data, 64'h0000_0001_2345_0000);
      @(posedge clk); #1 res_ready = 1'b1;
      wait_done();

      // Reset during the third issue cycle abandons the operation
      start_op(32'h0000_0007, 32'h0000_0009, 1'b0, 64'd63);
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("abort_mul_en", 64'(mul_en), 64'd0);
      check("abort_busy",   64'(busy),   64'd0);
      exp_q.delete();
      iss_q.delete();
      @(posedge clk); #1 reset = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_op_count", 64'(op_count), 64'd0);
      exp_count = '0;
      start_op(32'd3, 32'd5, 1'b0, 64'd15);
      wait_done();

      // Counter wrap: preload to 0xFFFF, one more completion wraps to 0
      @(posedge clk); #1;
      force dut.op_count = 16'hFFFF;
      #1 release dut.op_count;
      #1 check("preload_op_count", 64'(op_count), 64'h0000_0000_0000_FFFF);
      exp_count = 16'hFFFF;
      start_op(32'h0001_0000, 32'h0001_0000, 1'b1, 64'h0000_0001_0000_0000);
      wait_done();
      check("wrap_op_count", 64'(op_count), 64'd0);

      repeat (3) @(negedge clk);
      check("issue_queue_drained",  64'(iss_q.size()), 64'd0);
      check("result_queue_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 op_valid  input  1  requester presents an operation.
REQ-004 op_ready  output  1  block can accept an operation.
REQ-005 op_a  input  32  multiplicand.
REQ-006 op_b  input  32  multiplier.
REQ-007 op_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer accepts the result.
REQ-010 res_data  output  64  full 64-bit product.
REQ-011 mul_a  output  16  operand A to the shared 16x16 unsigned multiplier cell.
REQ-012 mul_b  output  16  operand B to the multiplier cell.
REQ-013 mul_en  output  1  multiplier cell clock enable; the cell registers the product at the edge ending a cycle with mul_en=1.
REQ-014 mul_result  input  32  cell output; valid in the cycle after the issue cycle.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 op_count  output  16  count of results delivered, wraps modulo 2^16.

Function
REQ-017 The states SHALL be IDLE, ISSUE, DRAIN, FIX and DONE.
REQ-018 op_ready SHALL be 1 only in IDLE; an operation is accepted in cycle T when op_valid & op_ready.
REQ-019 On acceptance the block SHALL latch op_a, op_b and op_signed, clear the 64-bit accumulator, and enter ISSUE.
REQ-020 ISSUE SHALL last 4 cycles (T+1..T+4) with mul_en=1, issuing in order: a[15:0]*b[15:0], a[15:0]*b[31:16], a[31:16]*b[15:0], a[31:16]*b[31:16].
REQ-021 mul_en SHALL be 0 in all non-ISSUE cycles; mul_a and mul_b SHALL be 0 outside ISSUE.
REQ-022 Each product SHALL be added to the accumulator in the cycle after its issue (T+2..T+5), left-shifted by 0, 16, 16 and 32 bits respectively.
REQ-023 Additions SHALL be 64-bit, with carries out of bit 63 discarded.
REQ-024 DRAIN (T+5) SHALL absorb the fourth product.
REQ-025 FIX (T+6) SHALL subtract, when op_signed=1, from accumulator bits [63:32], modulo 2^32: (a[31] ? b : 0) + (b[31] ? a : 0).
REQ-026 FIX SHALL apply no correction when op_signed=0.
REQ-027 res_valid SHALL rise in cycle T+7, giving a fixed latency of 7 cycles from acceptance.
REQ-028 In DONE, res_data SHALL stay stable and res_valid SHALL stay high until res_valid & res_ready.
REQ-029 On the result handshake the block SHALL return to IDLE in the next cycle and increment op_count by 1 (0xFFFF wraps to 0x0000).
REQ-030 There SHALL be no overlap between operations; minimum spacing between acceptances is 8 cycles.
REQ-031 op_valid, op_a and op_b changing outside the acceptance cycle SHALL have no effect.
REQ-032 res_ready asserted while res_valid=0 SHALL be ignored.

Reset
REQ-033 When reset is asserted, the block SHALL asynchronously enter IDLE with: op_ready=1 after release, res_valid=0, res_data=0, mul_en=0, mul_a=0, mul_b=0, busy=0, op_count=0, accumulator=0.
REQ-034 Reset asserted in any state, including mid-ISSUE, SHALL abandon the operation and produce no res_valid pulse.
REQ-035 mul_result arriving after reset release SHALL be ignored until a new ISSUE begins.

Verification
REQ-036 Unsigned 0xFFFFFFFF*0xFFFFFFFF, res_ready=1 -> res_data=0xFFFFFFFE_00000001 at T+7; op_count=1.
REQ-037 Signed 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000_00000001; signed 0x80000000*0x00000002 -> 0xFFFFFFFF_00000000.
REQ-038 Unsigned 0x00012345*0x00010000 with res_ready=0 for 5 cycles -> res_valid held with 0x00000001_23450000 stable; op_ready=0 throughout; IDLE one cycle after handshake.
REQ-039 Reset pulse in cycle T+3 -> mul_en=0 immediately, no res_valid, op_count unchanged at 0; a following op 3*5 -> 15.
REQ-040 Preload 65535 completions, then one more -> op_count=0x0000; mul_en high in exactly 4 cycles per operation, with the issue order checked.
